// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined register/immediate ALU:
// operation codes and positions of the result flags within the 4-bit flag word.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SLL = 3'b101,
    OP_SRL = 3'b110,
    OP_SRA = 3'b111
  } op_e;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/l_alu_core.sv
// Purely combinational ALU datapath: immediate sign extension, operation mux,
// optional signed saturation for ADD/SUB, and Z/N/C/V flag generation.
module l_alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int IMM_WIDTH = 9
) (
  input  logic [WIDTH-1:0]     in0,
  input  logic [IMM_WIDTH-1:0] immediate,
  input  logic [2:0]           op,
  input  logic                 sat_en,
  output logic [WIDTH-1:0]     result,
  output logic [3:0]           flags
);

  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;
  localparam logic [WIDTH:0]   ONE_W   = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] imm_x;
  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   add_w;
  logic [WIDTH:0]   sub_w;
  logic [WIDTH:0]   sll_w;
  logic [WIDTH:0]   srl_w;
  logic [WIDTH:0]   sra_w;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic             ovf;
  logic             arith;

  assign imm_x = WIDTH'($signed(immediate));
  assign shamt = imm_x[SHW-1:0];

  // Shifts run one bit wider so the last bit shifted out lands in the extra
  // position; a zero shift leaves that position clear, giving C=0 for free.
  always_comb begin
    add_w = {1'b0, in0} + {1'b0, imm_x};
    sub_w = {1'b0, in0} + {1'b0, ~imm_x} + ONE_W;
    sll_w = {1'b0, in0} << shamt;
    srl_w = {in0, 1'b0} >> shamt;
    sra_w = $signed({in0, 1'b0}) >>> shamt;

    res   = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    arith = 1'b0;

    case (op_e'(op))
      OP_ADD: begin
        res   = add_w[WIDTH-1:0];
        carry = add_w[WIDTH];
        ovf   = (in0[MSB] == imm_x[MSB]) && (add_w[MSB] != in0[MSB]);
        arith = 1'b1;
      end
      OP_SUB: begin
        res   = sub_w[WIDTH-1:0];
        carry = sub_w[WIDTH];
        ovf   = (in0[MSB] != imm_x[MSB]) && (sub_w[MSB] != in0[MSB]);
        arith = 1'b1;
      end
      OP_AND: res = in0 & imm_x;
      OP_OR:  res = in0 | imm_x;
      OP_XOR: res = in0 ^ imm_x;
      OP_SLL: begin
        res   = sll_w[WIDTH-1:0];
        carry = sll_w[WIDTH];
      end
      OP_SRL: begin
        res   = srl_w[WIDTH:1];
        carry = srl_w[0];
      end
      OP_SRA: begin
        res   = sra_w[WIDTH:1];
        carry = sra_w[0];
      end
      default: res = '0;
    endcase

    // Overflow direction follows the sign of in0: a non-negative in0 can only overflow upward.
    if (arith && sat_en && ovf) begin
      res = in0[MSB] ? SAT_MIN : SAT_MAX;
    end

    result         = res;
    flags          = '0;
    flags[FLAG_Z]  = (res == '0);
    flags[FLAG_N]  = res[MSB];
    flags[FLAG_C]  = carry;
    flags[FLAG_V]  = ovf;
  end

endmodule

// File: rtl/l_alu_pipe.sv
// Two-stage valid/ready pipelined ALU: S1 captures the accepted operation,
// S2 holds the computed result, flags and tag until the consumer takes it.
module l_alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int IMM_WIDTH = 9,
  parameter int TAG_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in0,
  input  logic [IMM_WIDTH-1:0] immediate,
  input  logic [2:0]           op,
  input  logic                 sat_en,
  input  logic [TAG_WIDTH-1:0] tag_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out,
  output logic [3:0]           flags,
  output logic [TAG_WIDTH-1:0] tag_out
);

  logic                 s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0]     s1_in0_q, s1_in0_d;
  logic [IMM_WIDTH-1:0] s1_imm_q, s1_imm_d;
  logic [2:0]           s1_op_q, s1_op_d;
  logic                 s1_sat_q, s1_sat_d;
  logic [TAG_WIDTH-1:0] s1_tag_q, s1_tag_d;

  logic                 s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0]     s2_out_q, s2_out_d;
  logic [3:0]           s2_flags_q, s2_flags_d;
  logic [TAG_WIDTH-1:0] s2_tag_q, s2_tag_d;

  logic                 s1_load;
  logic                 s2_load;
  logic [WIDTH-1:0]     core_result;
  logic [3:0]           core_flags;

  l_alu_core #(
    .WIDTH     (WIDTH),
    .IMM_WIDTH (IMM_WIDTH)
  ) u_core (
    .in0       (s1_in0_q),
    .immediate (s1_imm_q),
    .op        (s1_op_q),
    .sat_en    (s1_sat_q),
    .result    (core_result),
    .flags     (core_flags)
  );

  assign s2_load  = !s2_valid_q || out_ready;
  assign s1_load  = !s1_valid_q || s2_load;
  assign in_ready = s1_load;

  // Payload registers only move when a real operation arrives, so a stalled
  // or draining stage keeps presenting its last contents unchanged.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_in0_d   = s1_in0_q;
    s1_imm_d   = s1_imm_q;
    s1_op_d    = s1_op_q;
    s1_sat_d   = s1_sat_q;
    s1_tag_d   = s1_tag_q;
    s2_valid_d = s2_valid_q;
    s2_out_d   = s2_out_q;
    s2_flags_d = s2_flags_q;
    s2_tag_d   = s2_tag_q;

    if (s1_load) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_in0_d = in0;
        s1_imm_d = immediate;
        s1_op_d  = op;
        s1_sat_d = sat_en;
        s1_tag_d = tag_in;
      end
    end

    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_out_d   = core_result;
        s2_flags_d = core_flags;
        s2_tag_d   = s1_tag_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_in0_q   <= '0;
      s1_imm_q   <= '0;
      s1_op_q    <= '0;
      s1_sat_q   <= 1'b0;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_out_q   <= '0;
      s2_flags_q <= '0;
      s2_tag_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_in0_q   <= s1_in0_d;
      s1_imm_q   <= s1_imm_d;
      s1_op_q    <= s1_op_d;
      s1_sat_q   <= s1_sat_d;
      s1_tag_q   <= s1_tag_d;
      s2_valid_q <= s2_valid_d;
      s2_out_q   <= s2_out_d;
      s2_flags_q <= s2_flags_d;
      s2_tag_q   <= s2_tag_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out       = s2_out_q;
  assign flags     = s2_flags_q;
  assign tag_out   = s2_tag_q;

endmodule

// File: tb/tb_l_alu_pipe.sv
// Directed bench for l_alu_pipe: legacy add sweep, arithmetic/shift corner
// cases, backpressure ordering and reset with operations in flight.
module tb_l_alu_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in0;
  logic [8:0]  immediate;
  logic [2:0]  op;
  logic        sat_en;
  logic [3:0]  tag_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out;
  logic [3:0]  flags;
  logic [3:0]  tag_out;

  int check_count = 0;
  int error_count = 0;

  l_alu_pipe #(
    .WIDTH     (16),
    .IMM_WIDTH (9),
    .TAG_WIDTH (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in0       (in0),
    .immediate (immediate),
    .op        (op),
    .sat_en    (sat_en),
    .tag_in    (tag_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .flags     (flags),
    .tag_out   (tag_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Offers one operation and returns at the negedge after it was accepted.
  task automatic applyStimulus(input logic [15:0] a, input logic [8:0] imm, input logic [2:0] opc,
                               input logic sat, input logic [3:0] tag);
    bit accepted = 1'b0;
    @(negedge clk);
    in0       = a;
    immediate = imm;
    op        = opc;
    sat_en    = sat;
    tag_in    = tag;
    in_valid  = 1'b1;
    for (int i = 0; i < 20 && !accepted; i++) begin
      #1;
      if (in_ready) accepted = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!accepted) checkOutput("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic waitResult(input string name, input logic [15:0] exp_out, input logic [3:0] exp_flags,
                            input logic [3:0] exp_tag);
    bit seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (out_valid) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) begin
      checkOutput({name, "_timeout"}, 32'd0, 32'd1);
    end else begin
      checkOutput({name, "_out"}, 32'(out), 32'(exp_out));
      checkOutput({name, "_flags"}, 32'(flags), 32'(exp_flags));
      checkOutput({name, "_tag"}, 32'(tag_out), 32'(exp_tag));
    end
  endtask

  logic [15:0] exp_q[$];
  logic [3:0]  got_tags[$];
  logic [15:0] exp_val;
  logic [8:0]  imm_v;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in0       = '0;
    immediate = '0;
    op        = '0;
    sat_en    = 1'b0;
    tag_in    = '0;
    out_ready = 1'b1;

    #12;
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_out", 32'(out), 32'd0);
    checkOutput("reset_flags", 32'(flags), 32'd0);
    checkOutput("reset_tag", 32'(tag_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Legacy add-immediate regression, streamed one operation per cycle.
    $display("[TB] legacy ADD sweep");
    for (int i = 0; i < 300; i++) begin
      for (int j = 0; j < 200; j++) begin
        @(negedge clk);
        if (out_valid) begin
          if (exp_q.size() == 0) checkOutput("sweep_extra", 32'd1, 32'd0);
          else checkOutput("sweep_out", 32'(out), 32'(exp_q.pop_front()));
        end
        imm_v     = 9'(j);
        in0       = 16'(i * 171);
        immediate = imm_v;
        op        = 3'b000;
        sat_en    = 1'b0;
        tag_in    = 4'(j);
        in_valid  = 1'b1;
        #1;
        checkOutput("sweep_in_ready", 32'(in_ready), 32'd1);
        exp_val = 16'(i * 171) + {{7{imm_v[8]}}, imm_v};
        exp_q.push_back(exp_val);
      end
    end
    @(negedge clk);
    if (out_valid) begin
      if (exp_q.size() == 0) checkOutput("sweep_extra", 32'd1, 32'd0);
      else checkOutput("sweep_out", 32'(out), 32'(exp_q.pop_front()));
    end
    in_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (out_valid) begin
        if (exp_q.size() == 0) checkOutput("sweep_extra", 32'd1, 32'd0);
        else checkOutput("sweep_out", 32'(out), 32'(exp_q.pop_front()));
      end
    end
    checkOutput("sweep_drain", 32'(exp_q.size()), 32'd0);

    $display("[TB] directed arithmetic, logic and shift vectors");
    applyStimulus(16'h7FFF, 9'd1, 3'b000, 1'b0, 4'd1);
    waitResult("add_ovf", 16'h8000, 4'b0101, 4'd1);
    applyStimulus(16'h7FFF, 9'd1, 3'b000, 1'b1, 4'd2);
    waitResult("add_sat", 16'h7FFF, 4'b0001, 4'd2);
    applyStimulus(16'h8000, 9'h1FF, 3'b000, 1'b1, 4'd3);
    waitResult("add_sat_neg", 16'h8000, 4'b0111, 4'd3);
    applyStimulus(16'd5, 9'd5, 3'b001, 1'b0, 4'd4);
    waitResult("sub_zero", 16'h0000, 4'b1010, 4'd4);
    applyStimulus(16'd0, 9'd1, 3'b001, 1'b0, 4'd5);
    waitResult("sub_borrow", 16'hFFFF, 4'b0100, 4'd5);
    applyStimulus(16'h8000, 9'd1, 3'b001, 1'b1, 4'd6);
    waitResult("sub_sat_neg", 16'h8000, 4'b0111, 4'd6);
    applyStimulus(16'hF0F0, 9'h1FF, 3'b010, 1'b1, 4'd7);
    waitResult("and", 16'hF0F0, 4'b0100, 4'd7);
    applyStimulus(16'h0F00, 9'h0FF, 3'b011, 1'b0, 4'd8);
    waitResult("or", 16'h0FFF, 4'b0000, 4'd8);
    applyStimulus(16'h00FF, 9'h0FF, 3'b100, 1'b0, 4'd9);
    waitResult("xor", 16'h0000, 4'b1000, 4'd9);
    applyStimulus(16'h8000, 9'd15, 3'b111, 1'b0, 4'd10);
    waitResult("sra", 16'hFFFF, 4'b0100, 4'd10);
    applyStimulus(16'h8001, 9'd1, 3'b101, 1'b0, 4'd11);
    waitResult("sll", 16'h0002, 4'b0010, 4'd11);
    applyStimulus(16'h1234, 9'd0, 3'b110, 1'b0, 4'd12);
    waitResult("srl_zero", 16'h1234, 4'b0000, 4'd12);
    applyStimulus(16'h1235, 9'd4, 3'b110, 1'b0, 4'd13);
    waitResult("srl4", 16'h0123, 4'b0000, 4'd13);
    repeat (3) @(negedge clk);

    $display("[TB] backpressure");
    out_ready = 1'b0;
    in0 = 16'd100; immediate = 9'd1; op = 3'b000; sat_en = 1'b0; tag_in = 4'd1; in_valid = 1'b1;
    #1;
    checkOutput("bp_ready_1", 32'(in_ready), 32'd1);
    @(negedge clk);
    in0 = 16'd200; tag_in = 4'd2;
    #1;
    checkOutput("bp_ready_2", 32'(in_ready), 32'd1);
    @(negedge clk);
    in0 = 16'd300; tag_in = 4'd3;
    #1;
    checkOutput("bp_ready_full", 32'(in_ready), 32'd0);
    checkOutput("bp_head_tag", 32'(tag_out), 32'd1);
    @(negedge clk);
    @(negedge clk);
    checkOutput("bp_still_full", 32'(in_ready), 32'd0);
    checkOutput("bp_stable_out", 32'(out), 32'd101);
    checkOutput("bp_stable_tag", 32'(tag_out), 32'd1);
    out_ready = 1'b1;
    #1;
    checkOutput("bp_release_ready", 32'(in_ready), 32'd1);
    for (int c = 0; c < 8; c++) begin
      if (c == 1) in_valid = 1'b0;
      if (out_valid) got_tags.push_back(tag_out);
      @(negedge clk);
    end
    checkOutput("bp_count", 32'(got_tags.size()), 32'd3);
    for (int t = 0; t < got_tags.size() && t < 3; t++) begin
      checkOutput("bp_order", 32'(got_tags[t]), 32'(t + 1));
    end

    $display("[TB] reset with operations in flight");
    out_ready = 1'b0;
    applyStimulus(16'd10, 9'd1, 3'b000, 1'b0, 4'd5);
    applyStimulus(16'd20, 9'd1, 3'b000, 1'b0, 4'd6);
    checkOutput("rst_pre_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("rst_mid_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_mid_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_mid_out", 32'(out), 32'd0);
    checkOutput("rst_mid_flags", 32'(flags), 32'd0);
    checkOutput("rst_mid_tag", 32'(tag_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    applyStimulus(16'd40, 9'd2, 3'b000, 1'b0, 4'd9);
    waitResult("rst_after", 16'd42, 4'b0000, 4'd9);
    @(negedge clk);
    checkOutput("rst_no_stale", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
